data_ram_arbiter: RTL and testbench
===================================

# data_ram_arbiter

Two-requester arbiter sharing the single-port 32x1024 data RAM between the CPU load/store path and a host loader/debug port. Runs in the CPU clock domain and sits between the ALU/register-file memory outputs and the RAM instance. It forwards the winner's address, data and enables to the RAM and returns read data, tagged by owner, one cycle later. The CPU has fixed priority, and a starvation counter guarantees the host bounded service.

## Interface
- STARVE_LIMIT, 4: consecutive denied host-request cycles before the host is forced to win one grant (legal 1..15)
- ADDR_W, 10: RAM word-address width
- DATA_W, 32: RAM data width
- MAX10_CLK1_50  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU access request, held until granted
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU access accepted this cycle (combinational)
- cpu_stall  out  1  cpu_req & ~cpu_gnt; freezes PC
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DATA_W  CPU read data
- host_req, host_we, host_addr, host_wdata, host_gnt, host_rvalid, host_rdata: same meaning as the cpu_* ports, for the host
- ram_address  out  ADDR_W  to RAM address
- ram_data  out  DATA_W  to RAM data
- ram_rden  out  1  to RAM rden
- ram_wren  out  1  to RAM wren
- ram_q  in  DATA_W  RAM output, valid one cycle after a rden address edge

## Operation
- Arbitration is evaluated every cycle. Winner is host if host_req & (force_host | ~cpu_req). Otherwise winner is CPU if cpu_req. Otherwise there is no winner.
- force_host = (starve_cnt == STARVE_LIMIT).
- starve_cnt (4 bits):
  - cleared when host is granted or host_req is low
  - incremented when host_req is high and host is denied
  - saturates at STARVE_LIMIT
- At most one grant per cycle. The RAM bus is driven from the winner: ram_wren = winner_we, ram_rden = ~winner_we.
- With no winner, the RAM bus outputs 0 and both enables are 0.
- Read tracking: rd_owner register (NONE/CPU/HOST) loads the winner's ID on a granted read, otherwise NONE.
- Next cycle:
  - <owner>_rvalid = 1 and <owner>_rdata = ram_q
  - the other port's rdata holds its last value; rvalid = 0
- Writes produce no rvalid. A write is complete at the grant edge.
- Back-to-back grants are allowed every cycle, including a read immediately followed by a write from the other port. rd_owner already disambiguates the returning data.
- Requesters must keep req, we, addr and wdata stable until gnt. Behaviour on changes before grant is not defined.

## Timing
- Grant latency is 0 cycles: gnt is combinational from req and state.
- Read latency is 1 cycle: rvalid is asserted in cycle N+1 for a grant in cycle N.
- Worst-case host wait under continuous CPU traffic is STARVE_LIMIT cycles, granted in cycle STARVE_LIMIT+1. The CPU then stalls exactly one cycle.
- Reset values:
  - starve_cnt = 0, rd_owner = NONE
  - cpu_rvalid = host_rvalid = 0
  - cpu_rdata = host_rdata = 0
  - gnt, stall and RAM enables are forced 0 while reset is high
- Reset mid-read: a read granted in the cycle before reset asserts must yield no rvalid.
- Simultaneous requests with starve_cnt < STARVE_LIMIT: CPU wins. With starve_cnt == STARVE_LIMIT: host wins, and starve_cnt returns to 0 on the next edge.
- Simultaneous events: host dropping req in the same cycle the counter would hit the limit clears the counter (no latent force).

## Structure
- Shared package data_ram_pkg holds:
  - ADDR_W/DATA_W defaults
  - the owner_t enum {OWN_NONE, OWN_CPU, OWN_HOST}
  - STARVE_CNT_W = 4
- One sub-module, arb_starve_counter: saturating counter with inc/clr/limit inputs and an at_limit output.
- The winner mux, the rd_owner register and the read-return demux stay in the top module.

## Test plan
- Reset: hold reset 2 cycles with both reqs high. Required: all gnt/rvalid/enables are 0, starve_cnt = 0. First grant goes to CPU in the first cycle after release.
- CPU read: write 0xDEADBEEF to addr 0x3A via CPU, then read 0x3A. Required: cpu_gnt the same cycle, cpu_rvalid the next cycle with cpu_rdata = 0xDEADBEEF, host_rvalid = 0.
- Contention: CPU and host both request continuously with STARVE_LIMIT = 4. Required: host granted on cycle 5, cpu_stall high that cycle only; pattern repeats every 5 cycles.
- Interleaved returns: host read 0x001 in cycle N, CPU read 0x002 in cycle N+1 (RAM preloaded 0x11/0x22). Required: host_rdata = 0x11 at N+1, cpu_rdata = 0x22 at N+2.
- Reset mid-read: CPU read granted in cycle N, reset high in cycle N+1. Required: no cpu_rvalid, cpu_rdata = 0.
- Host-only writes: 8 consecutive host writes with CPU idle. Required: 8 grants in 8 cycles, starve_cnt stays 0, ram_wren high for 8 cycles.

Source files
------------

// File: rtl/data_ram_pkg.sv
// Shared types and defaults for the data RAM arbiter slice.
package data_ram_pkg;

   localparam int DEF_ADDR_W   = 10;
   localparam int DEF_DATA_W   = 32;
   localparam int STARVE_CNT_W = 4;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_HOST = 2'd2
   } owner_t;

endpackage

// File: rtl/data_ram_arbiter_if.sv
// Requester and RAM-side bus bundle; slave is the arbiter's view, master the surroundings.
interface data_ram_arbiter_if
   import data_ram_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);

   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_gnt;
   logic              cpu_stall;
   logic              cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;

   logic              host_req;
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic              host_gnt;
   logic              host_rvalid;
   logic [DATA_W-1:0] host_rdata;

   logic [ADDR_W-1:0] ram_address;
   logic [DATA_W-1:0] ram_data;
   logic              ram_rden;
   logic              ram_wren;
   logic [DATA_W-1:0] ram_q;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
      input  host_req, host_we, host_addr, host_wdata,
      output host_gnt, host_rvalid, host_rdata,
      output ram_address, ram_data, ram_rden, ram_wren,
      input  ram_q
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
      output host_req, host_we, host_addr, host_wdata,
      input  host_gnt, host_rvalid, host_rdata,
      input  ram_address, ram_data, ram_rden, ram_wren,
      output ram_q
   );

endinterface

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive denied host cycles; at_limit forces a host grant.
module arb_starve_counter
   import data_ram_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    inc,
   input  logic                    clr,
   input  logic [STARVE_CNT_W-1:0] limit,
   output logic [STARVE_CNT_W-1:0] count,
   output logic                    at_limit
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (inc && (count != limit)) begin
         count <= count + 1'b1;
      end
   end

   assign at_limit = (count == limit);

endmodule

// File: rtl/data_ram_arbiter.sv
// CPU/host arbiter for the single-port data RAM: fixed CPU priority with a
// starvation bound for the host, read data returned one cycle later by owner.
module data_ram_arbiter
   import data_ram_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W
)(
   input  logic               MAX10_CLK1_50,
   input  logic               reset,
   data_ram_arbiter_if.slave  bus
);

   localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

   logic                    at_limit;
   logic [STARVE_CNT_W-1:0] starve_cnt;
   logic                    host_win;
   logic                    cpu_win;
   logic [ADDR_W-1:0]       win_addr;
   logic [DATA_W-1:0]       win_data;
   logic                    win_we;
   logic                    win_any;

   owner_t                  rd_owner_p1;
   logic                    cpu_vld_p1;
   logic                    host_vld_p1;
   logic [DATA_W-1:0]       cpu_hold_p1;
   logic [DATA_W-1:0]       host_hold_p1;

   // Stage 0: combinational arbitration and winner mux onto the RAM bus
   assign host_win = ~reset & bus.host_req & (at_limit | ~bus.cpu_req);
   assign cpu_win  = ~reset & bus.cpu_req & ~host_win;

   assign bus.host_gnt  = host_win;
   assign bus.cpu_gnt   = cpu_win;
   assign bus.cpu_stall = ~reset & bus.cpu_req & ~cpu_win;

   arb_starve_counter u_starve (
      .clk      (MAX10_CLK1_50),
      .rst      (reset),
      .inc      (bus.host_req & ~host_win),
      .clr      (~bus.host_req | host_win),
      .limit    (LIMIT),
      .count    (starve_cnt),
      .at_limit (at_limit)
   );

   always_comb begin
      win_addr = '0;
      win_data = '0;
      win_we   = 1'b0;
      win_any  = 1'b0;
      if (host_win) begin
         win_addr = bus.host_addr;
         win_data = bus.host_wdata;
         win_we   = bus.host_we;
         win_any  = 1'b1;
      end else if (cpu_win) begin
         win_addr = bus.cpu_addr;
         win_data = bus.cpu_wdata;
         win_we   = bus.cpu_we;
         win_any  = 1'b1;
      end
   end

   assign bus.ram_address = win_addr;
   assign bus.ram_data    = win_data;
   assign bus.ram_wren    = win_any & win_we;
   assign bus.ram_rden    = win_any & ~win_we;

   // Stage 1: remember who owns the read in flight
   always_ff @(posedge MAX10_CLK1_50) begin
      if (reset) begin
         rd_owner_p1 <= OWN_NONE;
      end else if (host_win && !bus.host_we) begin
         rd_owner_p1 <= OWN_HOST;
      end else if (cpu_win && !bus.cpu_we) begin
         rd_owner_p1 <= OWN_CPU;
      end else begin
         rd_owner_p1 <= OWN_NONE;
      end
   end

   // Reset gates the return so a read granted just before reset never completes
   assign cpu_vld_p1  = ~reset & (rd_owner_p1 == OWN_CPU);
   assign host_vld_p1 = ~reset & (rd_owner_p1 == OWN_HOST);

   always_ff @(posedge MAX10_CLK1_50) begin
      if (reset) begin
         cpu_hold_p1  <= '0;
         host_hold_p1 <= '0;
      end else begin
         if (cpu_vld_p1)  cpu_hold_p1  <= bus.ram_q;
         if (host_vld_p1) host_hold_p1 <= bus.ram_q;
      end
   end

   assign bus.cpu_rvalid  = cpu_vld_p1;
   assign bus.host_rvalid = host_vld_p1;
   assign bus.cpu_rdata   = cpu_vld_p1  ? bus.ram_q : cpu_hold_p1;
   assign bus.host_rdata  = host_vld_p1 ? bus.ram_q : host_hold_p1;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Bench for data_ram_arbiter: directed scenarios plus random traffic against a
// cycle-level reference model of grants, starvation and read returns.
module tb_data_ram_arbiter;

   localparam int LIMIT = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   data_ram_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

   data_ram_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(10), .DATA_W(32)) dut (
      .MAX10_CLK1_50 (clk),
      .reset         (reset),
      .bus           (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] ram_mem [1024];
   logic [31:0] m_mem   [1024];

   logic        rst_v;
   logic        c_req, c_we, h_req, h_we;
   logic [9:0]  c_addr, h_addr;
   logic [31:0] c_wd, h_wd;

   int          m_starve;
   int          m_own;
   logic [31:0] m_rdata, m_cpu_last, m_host_last;
   bit          chk_state;

   bit          e_cw, e_hw;
   logic        o_cgnt, o_hgnt, o_stall, o_wren, o_crv, o_hrv;
   logic [31:0] o_crd, o_hrd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      logic [9:0]  ra;
      logic [31:0] rd;
      logic        rw, rr;
      bit          cv, hv;
      @(negedge clk);
      reset          = rst_v;
      bus.cpu_req    = c_req;
      bus.cpu_we     = c_we;
      bus.cpu_addr   = c_addr;
      bus.cpu_wdata  = c_wd;
      bus.host_req   = h_req;
      bus.host_we    = h_we;
      bus.host_addr  = h_addr;
      bus.host_wdata = h_wd;
      #1;
      e_hw = !rst_v && h_req && (!c_req || m_starve >= LIMIT);
      e_cw = !rst_v && c_req && !e_hw;
      chk("cpu_gnt", bus.cpu_gnt, e_cw);
      chk("host_gnt", bus.host_gnt, e_hw);
      chk("cpu_stall", bus.cpu_stall, !rst_v && c_req && !e_cw);
      chk("ram_wren", bus.ram_wren, (e_hw && h_we) || (e_cw && c_we));
      chk("ram_rden", bus.ram_rden, (e_hw && !h_we) || (e_cw && !c_we));
      chk("ram_address", bus.ram_address, e_hw ? 32'(h_addr) : e_cw ? 32'(c_addr) : 32'd0);
      chk("ram_data", bus.ram_data, e_hw ? h_wd : e_cw ? c_wd : 32'd0);
      cv = !rst_v && m_own == 1;
      hv = !rst_v && m_own == 2;
      chk("cpu_rvalid", bus.cpu_rvalid, cv);
      chk("host_rvalid", bus.host_rvalid, hv);
      if (chk_state) begin
         chk("cpu_rdata", bus.cpu_rdata, cv ? m_rdata : m_cpu_last);
         chk("host_rdata", bus.host_rdata, hv ? m_rdata : m_host_last);
         chk("starve_cnt", 32'(dut.u_starve.count), m_starve);
      end
      o_cgnt  = bus.cpu_gnt;
      o_hgnt  = bus.host_gnt;
      o_stall = bus.cpu_stall;
      o_wren  = bus.ram_wren;
      o_crv   = bus.cpu_rvalid;
      o_hrv   = bus.host_rvalid;
      o_crd   = bus.cpu_rdata;
      o_hrd   = bus.host_rdata;
      ra = bus.ram_address;
      rd = bus.ram_data;
      rw = bus.ram_wren;
      rr = bus.ram_rden;
      if (cv) m_cpu_last = m_rdata;
      if (hv) m_host_last = m_rdata;
      if (rst_v) begin
         m_starve    = 0;
         m_own       = 0;
         m_cpu_last  = 0;
         m_host_last = 0;
      end else begin
         m_own = 0;
         if (e_hw) begin
            if (h_we) m_mem[h_addr] = h_wd;
            else begin m_own = 2; m_rdata = m_mem[h_addr]; end
         end else if (e_cw) begin
            if (c_we) m_mem[c_addr] = c_wd;
            else begin m_own = 1; m_rdata = m_mem[c_addr]; end
         end
         if (h_req && !e_hw) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
         else m_starve = 0;
      end
      chk_state = 1'b1;
      @(posedge clk);
      #1;
      if (rw) ram_mem[ra] = rd;
      if (rr) bus.ram_q = ram_mem[ra];
   endtask

   initial begin
      int hg_cnt;
      int wr_cnt;
      bit hist_h [10];
      bit hist_s [10];
      for (int i = 0; i < 1024; i++) begin
         logic [31:0] v;
         v = $urandom;
         ram_mem[i] = v;
         m_mem[i]   = v;
      end
      ram_mem[1] = 32'h11; m_mem[1] = 32'h11;
      ram_mem[2] = 32'h22; m_mem[2] = 32'h22;
      bus.ram_q = '0;
      m_starve = 0; m_own = 0; m_rdata = 0; m_cpu_last = 0; m_host_last = 0;
      chk_state = 1'b0;
      c_wd = 0; h_wd = 0;

      // Reset held two cycles with both requesters active
      rst_v = 1; c_req = 1; c_we = 0; c_addr = 10'd5; h_req = 1; h_we = 0; h_addr = 10'd6;
      cyc();
      cyc();
      chk("reset_cpu_gnt", o_cgnt, 1'b0);
      chk("reset_host_gnt", o_hgnt, 1'b0);
      chk("reset_wren", o_wren, 1'b0);
      rst_v = 0;
      cyc();
      chk("first_grant_cpu", o_cgnt, 1'b1);
      chk("first_grant_not_host", o_hgnt, 1'b0);

      // CPU write then read of 0x3A
      h_req = 0;
      c_req = 1; c_we = 1; c_addr = 10'h3A; c_wd = 32'hDEADBEEF;
      cyc();
      c_we = 0; c_wd = 0;
      cyc();
      chk("cpu_read_gnt", o_cgnt, 1'b1);
      c_req = 0;
      cyc();
      chk("cpu_read_rvalid", o_crv, 1'b1);
      chk("cpu_read_data", o_crd, 32'hDEADBEEF);
      chk("cpu_read_host_rvalid", o_hrv, 1'b0);

      // Continuous contention: host wins every fifth cycle
      c_req = 1; c_we = 0; c_addr = 10'h10;
      h_req = 1; h_we = 0; h_addr = 10'h20;
      for (int i = 0; i < 10; i++) begin
         cyc();
         hist_h[i] = o_hgnt;
         hist_s[i] = o_stall;
      end
      for (int i = 0; i < 10; i++) begin
         chk("contention_host_gnt", 32'(hist_h[i]), 32'((i % 5) == 4));
         chk("contention_stall", 32'(hist_s[i]), 32'((i % 5) == 4));
      end
      c_req = 0; h_req = 0;
      cyc();

      // Interleaved returns: host read 1, then CPU read 2
      h_req = 1; h_we = 0; h_addr = 10'd1;
      cyc();
      h_req = 0; c_req = 1; c_we = 0; c_addr = 10'd2;
      cyc();
      chk("interleave_host_rvalid", o_hrv, 1'b1);
      chk("interleave_host_rdata", o_hrd, 32'h11);
      c_req = 0;
      cyc();
      chk("interleave_cpu_rvalid", o_crv, 1'b1);
      chk("interleave_cpu_rdata", o_crd, 32'h22);
      chk("interleave_host_hold", o_hrd, 32'h11);

      // Reset lands the cycle after a granted CPU read
      c_req = 1; c_we = 0; c_addr = 10'h3A;
      cyc();
      c_req = 0; rst_v = 1;
      cyc();
      chk("midread_rvalid_in_reset", o_crv, 1'b0);
      rst_v = 0;
      cyc();
      chk("midread_rvalid_after", o_crv, 1'b0);
      chk("midread_rdata_after", o_crd, 32'h0);

      // Eight back-to-back host writes with CPU idle
      hg_cnt = 0; wr_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         h_req = 1; h_we = 1; h_addr = 10'(100 + i); h_wd = $urandom;
         cyc();
         hg_cnt += int'(o_hgnt);
         wr_cnt += int'(o_wren);
      end
      chk("host_writes_grants", hg_cnt, 8);
      chk("host_writes_wren", wr_cnt, 8);

      // Random traffic; requests are held until granted
      for (int k = 0; k < 400; k++) begin
         if (!h_req || e_hw) begin
            h_req  = ($urandom_range(0, 1) == 1);
            h_we   = $urandom_range(0, 1);
            h_addr = 10'($urandom_range(0, 15));
            h_wd   = $urandom;
         end
         if (!c_req || e_cw) begin
            c_req  = ($urandom_range(0, 3) != 0);
            c_we   = $urandom_range(0, 1);
            c_addr = 10'($urandom_range(0, 15));
            c_wd   = $urandom;
         end
         rst_v = ($urandom_range(0, 99) == 0);
         cyc();
      end
      rst_v = 0; c_req = 0; h_req = 0;
      cyc();
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
